alu_exec_unit: RTL and testbench
================================

// Module: alu_exec_unit
// PURPOSE
//  Execute-stage ALU that consumes the 3-bit operation select produced by the ALU control decoder.
//  Accepts operands via valid/ready, computes one of eight ops, returns a registered result.
//  Flags returned with every result: zero (for beq/bne) and signed overflow.
//  SLL runs on a serial shifter (1 bit/cycle) unless the fast-shift option is compiled in.
// PARAMETERS
//  WIDTH   32   operand/result width (>=8, power of 2)
//  SHW     5    shift-amount width, = log2(WIDTH)
// PORTS
//  clk        in   1      single clock, rising edge
//  rst_n      in   1      asynchronous active-low reset
//  in_valid   in   1      operand/op bundle valid
//  in_ready   out  1      unit can accept a bundle this cycle
//  sel        in   3      operation select (encoding below)
//  a          in   WIDTH  operand A (rs)
//  b          in   WIDTH  operand B (rt or sign-extended immediate)
//  shamt      in   SHW    shift amount, used only by SLL
//  out_valid  out  1      result/flags valid
//  out_ready  in   1      downstream accepts result
//  result     out  WIDTH  operation result
//  zero       out  1      result == 0
//  ovf        out  1      signed overflow (meaningful for sel 010/110 only; 0 otherwise)
// BEHAVIOUR
//  sel encoding (fixed; matches decoder): 000 AND, 001 OR, 010 ADD, 011 SLT, 100 ADDU,
//   101 SLL (b << shamt), 110 SUB (also SUBU and branch compare), 111 SLTU.
//  Arithmetic: modulo 2^WIDTH. SLT/SLTU: result = {WIDTH-1 zeros, lt}, signed/unsigned compare of a, b.
//  ovf: ADD = (a[msb]==b[msb]) && (r[msb]!=a[msb]); SUB = (a[msb]!=b[msb]) && (r[msb]!=a[msb]).
//  Reset (async, rst_n=0): state=IDLE, out_valid=0, result=0, zero=0, ovf=0, shift count=0.
//  FSM: IDLE -> (accept, sel!=101 or shamt==0) -> HOLD; IDLE -> (accept SLL, shamt!=0) -> SHIFT;
//   SHIFT: shift reg <<1, count-1 each cycle; count==1 -> HOLD; HOLD: out_valid=1; out_ready -> IDLE,
//   or directly to next SHIFT/HOLD if a new bundle is accepted in the same cycle.
//  Accept = in_valid && in_ready. in_ready = (state==IDLE) || (state==HOLD && out_ready).
//  Latency (accept -> out_valid): 1 cycle for all non-SLL ops and SLL with shamt 0; shamt+1 for serial SLL.
//  Back-to-back: with out_ready held 1, one non-SLL result per cycle, no bubbles.
//  HOLD with out_ready=0: result/zero/ovf stable; in_ready=0.
//  Inputs sampled only at accept; changes to a/b/sel/shamt during SHIFT/HOLD are ignored.
//  Reset asserted mid-SHIFT or in HOLD: pending op dropped, outputs return to reset values at once.
//  Unused op bits never produce X: all 8 sel codes are defined.
// CONFIGURATION
//  ALU_FAST_SHIFT_EN defined: SLL uses a combinational barrel shifter; SHIFT state unused/absent;
//   SLL latency 1 cycle like all other ops, full throughput.
//  Undefined (default): serial shifter as above; in_ready low for the shamt cycles of each SLL.
// STRUCTURE
//  Shared package alu_pkg: localparams ALU_AND..ALU_SLTU (3-bit sel codes), FSM state codes
//   (IDLE, SHIFT, HOLD), default WIDTH. The decoder and this unit both use alu_pkg codes.
//  One sub-module: alu_serial_shifter (load, shamt, step, done, data) holding shift reg + down-counter;
//   replaced by the barrel path when ALU_FAST_SHIFT_EN is defined.
//  Top holds FSM, combinational op mux, flag logic, output registers.
// TESTING
//  1. Reset: rst_n=0 async mid-cycle -> out_valid=0, result=0, zero=0, ovf=0, in_ready=1 after release.
//  2. ADD a=0x7FFFFFFF b=1 sel=010 -> 1 cycle later result=0x80000000, ovf=1, zero=0; same with
//     sel=100 -> ovf=0.
//  3. SUB a=5 b=5 sel=110 -> result=0, zero=1; SLT a=0xFFFFFFFF b=1 -> 1; SLTU same -> 0.
//  4. SLL b=0x1 shamt=31 (serial) -> in_ready=0 for 31 cycles, out_valid at cycle 32, result=0x80000000;
//     shamt=0 -> 1-cycle latency, result=b.
//  5. Backpressure: out_ready=0 in HOLD for 5 cycles -> result stable, in_ready=0; stream of
//     8 ANDs/ORs with out_ready=1 -> 8 results on 8 consecutive cycles.
//  6. rst_n pulsed during SLL shamt=20 at cycle 10 -> no result emitted; next ADD completes normally.
//  Run 2-6 with and without ALU_FAST_SHIFT_EN (case 4 expects 1-cycle latency when defined).

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU definitions: operation select codes (common with the ALU control decoder),
// execute-unit FSM state codes and the default datapath width.
package alu_pkg;

  localparam int ALU_WIDTH = 32;

  localparam logic [2:0] ALU_AND  = 3'b000;
  localparam logic [2:0] ALU_OR   = 3'b001;
  localparam logic [2:0] ALU_ADD  = 3'b010;
  localparam logic [2:0] ALU_SLT  = 3'b011;
  localparam logic [2:0] ALU_ADDU = 3'b100;
  localparam logic [2:0] ALU_SLL  = 3'b101;
  localparam logic [2:0] ALU_SUB  = 3'b110;
  localparam logic [2:0] ALU_SLTU = 3'b111;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    HOLD  = 2'd2
  } alu_state_e;

endpackage

// File: rtl/alu_serial_shifter.sv
// One-bit-per-step left shifter with a down-counter; o_done marks the final step and
// o_data is the value the register reaches after the current step.
module alu_serial_shifter
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_load,
  input  logic [SHW-1:0]   i_shamt,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_step,
  output logic             o_done,
  output logic [WIDTH-1:0] o_data
);

  logic [WIDTH-1:0] r_sh;
  logic [SHW-1:0]   r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sh  <= '0;
      r_cnt <= '0;
    end else if (i_load) begin
      r_sh  <= i_data;
      r_cnt <= i_shamt;
    end else if (i_step && (r_cnt != '0)) begin
      r_sh  <= {r_sh[WIDTH-2:0], 1'b0};
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_done = (r_cnt == SHW'(1));
  assign o_data = {r_sh[WIDTH-2:0], 1'b0};

endmodule

// File: rtl/alu_exec_unit.sv
// Execute-stage ALU: valid/ready operand bundle in, registered result + zero/ovf out.
// Latency 1 (serial SLL: shamt+1); in_ready drops while shifting or while a result is stalled.
// ALU_FAST_SHIFT_EN selects a single-cycle barrel SLL instead of the serial shifter.
module alu_exec_unit
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       sel,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [SHW-1:0]   shamt,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             ovf
);

  alu_state_e       r_state;
  logic             r_out_valid;
  logic [WIDTH-1:0] r_result;
  logic             r_zero;
  logic             r_ovf;

  logic [WIDTH-1:0] w_sum;
  logic [WIDTH-1:0] w_diff;
  logic [WIDTH-1:0] w_res;
  logic             w_ovf;
  logic             w_accept;
  logic             w_go_shift;

  assign w_sum    = a + b;
  assign w_diff   = a - b;
  assign in_ready = (r_state == IDLE) || ((r_state == HOLD) && out_ready);
  assign w_accept = in_valid && in_ready;

  always_comb begin
    w_res = '0;
    w_ovf = 1'b0;
    case (sel)
      ALU_AND:  w_res = a & b;
      ALU_OR:   w_res = a | b;
      ALU_ADD: begin
        w_res = w_sum;
        w_ovf = (a[WIDTH-1] == b[WIDTH-1]) && (w_sum[WIDTH-1] != a[WIDTH-1]);
      end
      ALU_SLT:  w_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      ALU_ADDU: w_res = w_sum;
`ifdef ALU_FAST_SHIFT_EN
      ALU_SLL:  w_res = b << shamt;
`else
      // Only reaches the output register when shamt == 0; other shifts go serial.
      ALU_SLL:  w_res = b;
`endif
      ALU_SUB: begin
        w_res = w_diff;
        w_ovf = (a[WIDTH-1] != b[WIDTH-1]) && (w_diff[WIDTH-1] != a[WIDTH-1]);
      end
      ALU_SLTU: w_res = {{(WIDTH-1){1'b0}}, (a < b)};
      default:  w_res = '0;
    endcase
  end

`ifdef ALU_FAST_SHIFT_EN
  assign w_go_shift = 1'b0;
`else
  logic             w_sh_done;
  logic [WIDTH-1:0] w_sh_data;

  assign w_go_shift = (sel == ALU_SLL) && (shamt != '0);

  alu_serial_shifter #(
    .WIDTH (WIDTH),
    .SHW   (SHW)
  ) u_shifter (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_load  (w_accept && w_go_shift),
    .i_shamt (shamt),
    .i_data  (b),
    .i_step  (r_state == SHIFT),
    .o_done  (w_sh_done),
    .o_data  (w_sh_data)
  );
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_out_valid <= 1'b0;
      r_result    <= '0;
      r_zero      <= 1'b0;
      r_ovf       <= 1'b0;
    end else begin
      case (r_state)
        IDLE, HOLD: begin
          if (w_accept && w_go_shift) begin
            r_state     <= SHIFT;
            r_out_valid <= 1'b0;
          end else if (w_accept) begin
            r_state     <= HOLD;
            r_out_valid <= 1'b1;
            r_result    <= w_res;
            r_zero      <= (w_res == '0);
            r_ovf       <= w_ovf;
          end else if ((r_state == HOLD) && out_ready) begin
            r_state     <= IDLE;
            r_out_valid <= 1'b0;
          end
        end
`ifndef ALU_FAST_SHIFT_EN
        SHIFT: begin
          if (w_sh_done) begin
            r_state     <= HOLD;
            r_out_valid <= 1'b1;
            r_result    <= w_sh_data;
            r_zero      <= (w_sh_data == '0);
            r_ovf       <= 1'b0;
          end
        end
`endif
        default: r_state <= IDLE;
      endcase
    end
  end

  assign out_valid = r_out_valid;
  assign result    = r_result;
  assign zero      = r_zero;
  assign ovf       = r_ovf;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Self-checking bench for alu_exec_unit: directed corner cases plus randomized ops
// against a arithmetic reference model; latency expectations follow ALU_FAST_SHIFT_EN.
module tb_alu_exec_unit;

  localparam logic [2:0] OP_AND = 3'b000, OP_OR = 3'b001, OP_ADD = 3'b010, OP_SLT = 3'b011;
  localparam logic [2:0] OP_ADDU = 3'b100, OP_SLL = 3'b101, OP_SUB = 3'b110, OP_SLTU = 3'b111;
  localparam longint S_MAX = 64'sd2147483647;
  localparam longint S_MIN = -64'sd2147483648;
`ifdef ALU_FAST_SHIFT_EN
  localparam bit FAST = 1'b1;
`else
  localparam bit FAST = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [2:0]  sel = '0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic [4:0]  shamt = '0;
  logic        in_ready;
  logic        out_valid;
  logic [31:0] result;
  logic        zero;
  logic        ovf;

  int n_pass = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  alu_exec_unit #(.WIDTH(32), .SHW(5)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .sel(sel), .a(a), .b(b), .shamt(shamt),
    .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .zero(zero), .ovf(ovf)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: signed ops evaluated in 64-bit integers, overflow = out of 32-bit signed range.
  function automatic void model(input logic [2:0] s, input logic [31:0] av, input logic [31:0] bv,
                                input logic [4:0] sh, output logic [31:0] r, output logic o);
    longint sa, sb, t;
    sa = longint'($signed(av));
    sb = longint'($signed(bv));
    t  = 0;
    r  = '0;
    o  = 1'b0;
    case (s)
      OP_AND:  r = av & bv;
      OP_OR:   r = av | bv;
      OP_ADD:  begin t = sa + sb; r = t[31:0]; o = (t > S_MAX) || (t < S_MIN); end
      OP_SLT:  r = (sa < sb) ? 32'd1 : 32'd0;
      OP_ADDU: r = av + bv;
      OP_SLL:  r = 32'(longint'(bv) * (longint'(1) << sh));
      OP_SUB:  begin t = sa - sb; r = t[31:0]; o = (t > S_MAX) || (t < S_MIN); end
      default: r = (av < bv) ? 32'd1 : 32'd0;
    endcase
  endfunction

  // Issues one op from IDLE, checks latency, busy cycles, outputs and stall stability.
  task automatic do_op(input logic [2:0] s, input logic [31:0] av, input logic [31:0] bv,
                       input logic [4:0] sh, input int stall,
                       output logic [31:0] got_r, output logic got_z, output logic got_o);
    logic [31:0] er;
    logic        eo;
    int          lat, exp_lat, busy;
    model(s, av, bv, sh, er, eo);
    exp_lat = (s == OP_SLL && sh != 0 && !FAST) ? int'(sh) + 1 : 1;
    sel = s; a = av; b = bv; shamt = sh; in_valid = 1'b1; out_ready = (stall == 0);
    #1;
    n_total++;
    if (in_ready !== 1'b1) $display("FAIL accept_ready sel=%0d got=%b want=1", s, in_ready);
    else n_pass++;
    @(posedge clk); #1;
    in_valid = 1'b0;
    a = $urandom; b = $urandom; sel = 3'($urandom); shamt = 5'($urandom);
    lat = 1; busy = 0;
    while (out_valid !== 1'b1 && lat < 100) begin
      if (in_ready === 1'b0) busy++;
      tick();
      lat++;
    end
    got_r = result; got_z = zero; got_o = ovf;
    n_total++;
    if (lat != exp_lat) $display("FAIL latency sel=%0d sh=%0d got=%0d want=%0d", s, sh, lat, exp_lat);
    else n_pass++;
    n_total++;
    if (busy != exp_lat - 1) $display("FAIL busy_cycles sel=%0d got=%0d want=%0d", s, busy, exp_lat - 1);
    else n_pass++;
    n_total++;
    if ({result, zero, ovf} !== {er, (er == 32'd0), eo})
      $display("FAIL result sel=%0d a=%h b=%h sh=%0d got=%h/z%b/o%b want=%h/z%b/o%b",
               s, av, bv, sh, result, zero, ovf, er, (er == 32'd0), eo);
    else n_pass++;
    for (int k = 0; k < stall; k++) begin
      tick();
      n_total++;
      if ({out_valid, in_ready, result, zero, ovf} !== {1'b1, 1'b0, er, (er == 32'd0), eo})
        $display("FAIL stall_hold cyc=%0d got v%b r%b %h want v1 r0 %h", k, out_valid, in_ready, result, er);
      else n_pass++;
    end
    out_ready = 1'b1;
    tick();
    n_total++;
    if (out_valid !== 1'b0) $display("FAIL drain got=%b want=0", out_valid);
    else n_pass++;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    #13;
    n_total++;
    if ({out_valid, result, zero, ovf} !== 35'd0) $display("FAIL reset_outs got=%h want=0", {out_valid, result, zero, ovf});
    else n_pass++;
    #4 rst_n = 1'b1;
    tick();
    n_total++;
    if ({in_ready, out_valid} !== 2'b10) $display("FAIL reset_release got=%b want=10", {in_ready, out_valid});
    else n_pass++;
    sel = OP_ADD; a = 32'h7FFF_FFFF; b = 32'd1; in_valid = 1'b1; out_ready = 1'b0;
    tick();
    in_valid = 1'b0;
    n_total++;
    if ({out_valid, ovf} !== 2'b11) $display("FAIL pre_reset_hold got=%b want=11", {out_valid, ovf});
    else n_pass++;
    #2 rst_n = 1'b0;
    #1;
    n_total++;
    if ({out_valid, result, zero, ovf} !== 35'd0) $display("FAIL async_reset_hold got=%h want=0", {out_valid, result, zero, ovf});
    else n_pass++;
    #2 rst_n = 1'b1;
    out_ready = 1'b1;
    tick();
    n_total++;
    if ({in_ready, out_valid} !== 2'b10) $display("FAIL reset_idle got=%b want=10", {in_ready, out_valid});
    else n_pass++;
  endtask

  task automatic test_add();
    logic [31:0] r; logic z, o;
    do_op(OP_ADD, 32'h7FFF_FFFF, 32'd1, 5'd0, 0, r, z, o);
    n_total++;
    if ({r, z, o} !== {32'h8000_0000, 1'b0, 1'b1}) $display("FAIL add_ovf got=%h/%b/%b want=80000000/0/1", r, z, o);
    else n_pass++;
    do_op(OP_ADDU, 32'h7FFF_FFFF, 32'd1, 5'd0, 0, r, z, o);
    n_total++;
    if ({r, z, o} !== {32'h8000_0000, 1'b0, 1'b0}) $display("FAIL addu_noovf got=%h/%b/%b want=80000000/0/0", r, z, o);
    else n_pass++;
  endtask

  task automatic test_sub_slt();
    logic [31:0] r; logic z, o;
    do_op(OP_SUB, 32'd5, 32'd5, 5'd0, 0, r, z, o);
    n_total++;
    if ({r, z, o} !== {32'd0, 1'b1, 1'b0}) $display("FAIL sub_zero got=%h/%b/%b want=0/1/0", r, z, o);
    else n_pass++;
    do_op(OP_SLT, 32'hFFFF_FFFF, 32'd1, 5'd0, 0, r, z, o);
    n_total++;
    if (r !== 32'd1) $display("FAIL slt_signed got=%h want=1", r);
    else n_pass++;
    do_op(OP_SLTU, 32'hFFFF_FFFF, 32'd1, 5'd0, 0, r, z, o);
    n_total++;
    if ({r, z} !== {32'd0, 1'b1}) $display("FAIL sltu_unsigned got=%h/%b want=0/1", r, z);
    else n_pass++;
  endtask

  task automatic test_sll();
    logic [31:0] r; logic z, o;
    do_op(OP_SLL, 32'h0, 32'd1, 5'd31, 0, r, z, o);
    n_total++;
    if (r !== 32'h8000_0000) $display("FAIL sll31 got=%h want=80000000", r);
    else n_pass++;
    do_op(OP_SLL, 32'h0, 32'hDEAD_BEEF, 5'd0, 0, r, z, o);
    n_total++;
    if (r !== 32'hDEAD_BEEF) $display("FAIL sll0 got=%h want=deadbeef", r);
    else n_pass++;
    do_op(OP_SLL, 32'h0, 32'hF000_0001, 5'd1, 2, r, z, o);
  endtask

  task automatic test_backpressure();
    logic [31:0] r; logic z, o;
    do_op(OP_OR, $urandom, $urandom, 5'd0, 5, r, z, o);
    do_op(OP_SUB, 32'h8000_0000, 32'd1, 5'd0, 5, r, z, o);
  endtask

  task automatic test_back_to_back();
    logic [2:0]  s  [8];
    logic [31:0] av [8];
    logic [31:0] bv [8];
    logic [31:0] er [8];
    logic        eo;
    for (int i = 0; i < 8; i++) begin
      s[i] = (i % 2 == 0) ? OP_AND : OP_OR;
      av[i] = $urandom; bv[i] = $urandom;
      model(s[i], av[i], bv[i], 5'd0, er[i], eo);
    end
    sel = s[0]; a = av[0]; b = bv[0]; shamt = '0; in_valid = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      n_total++;
      if ({out_valid, in_ready, result} !== {1'b1, 1'b1, er[i]})
        $display("FAIL b2b_%0d got v%b r%b %h want v1 r1 %h", i, out_valid, in_ready, result, er[i]);
      else n_pass++;
      if (i < 7) begin sel = s[i+1]; a = av[i+1]; b = bv[i+1]; end
      else in_valid = 1'b0;
    end
    tick();
    n_total++;
    if (out_valid !== 1'b0) $display("FAIL b2b_end got=%b want=0", out_valid);
    else n_pass++;
  endtask

  task automatic test_reset_mid_shift();
    logic [31:0] r; logic z, o;
    int seen_before, seen_after;
    sel = OP_SLL; a = '0; b = 32'd1; shamt = 5'd20; in_valid = 1'b1; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    seen_before = 0;
    for (int k = 1; k < 10; k++) begin
      if (out_valid === 1'b1) seen_before++;
      tick();
    end
    #2 rst_n = 1'b0;
    #1;
    n_total++;
    if (out_valid !== 1'b0) $display("FAIL mid_shift_reset got=%b want=0", out_valid);
    else n_pass++;
    #2 rst_n = 1'b1;
    seen_after = 0;
    for (int k = 0; k < 25; k++) begin
      tick();
      if (out_valid === 1'b1) seen_after++;
    end
    n_total++;
    if (seen_before != int'(FAST) || seen_after != 0)
      $display("FAIL shift_dropped got=%0d/%0d want=%0d/0", seen_before, seen_after, int'(FAST));
    else n_pass++;
    do_op(OP_ADD, $urandom, $urandom, 5'd0, 0, r, z, o);
  endtask

  task automatic test_random();
    logic [31:0] r; logic z, o;
    logic [4:0]  sh;
    for (int i = 0; i < 80; i++) begin
      sh = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 3));
      do_op(3'($urandom_range(0, 7)), $urandom, $urandom, sh, $urandom_range(0, 2), r, z, o);
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub_slt();
    test_sll();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_shift();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
